// File: rtl/sc_reg_jug_mover.sv
// Player position register for a button-driven game: shifts a bit pattern left or
// right while a button is held, with an initial move, a hold-off delay and then auto-repeat.
module sc_reg_jug_mover #(
  parameter int                             RegJUGMOV_DATAWIDTH = 8,
  parameter logic [RegJUGMOV_DATAWIDTH-1:0] DATA_INIT_POS       = 8'b00011000,
  parameter bit                             WRAP_MODE           = 1'b1,
  parameter int                             REPEAT_DELAY        = 12500000,
  parameter int                             REPEAT_PERIOD       = 5000000
) (
  input  logic                           SC_RegJUGMOV_CLOCK_50,
  input  logic                           SC_RegJUGMOV_RESET_InLow,
  input  logic                           SC_RegJUGMOV_clear_InLow,
  input  logic                           SC_RegJUGMOV_load_InLow,
  input  logic                           SC_RegJUGMOV_left_InLow,
  input  logic                           SC_RegJUGMOV_right_InLow,
  output logic [RegJUGMOV_DATAWIDTH-1:0] SC_RegJUGMOV_data_OutBUS,
  output logic                           SC_RegJUGMOV_edge_Out
);

  localparam int W         = RegJUGMOV_DATAWIDTH;
  localparam int MaxCount  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CntW      = (MaxCount > 1) ? $clog2(MaxCount) : 1;
  localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_data;
  logic [W-1:0]    w_data_nxt;
  logic            r_edge;
  logic            w_edge_nxt;
  logic            r_dir;
  logic            w_dir_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  logic            w_left_req;
  logic            w_right_req;
  logic            w_req;
  logic [W-1:0]    w_move_data;
  logic            w_move_edge;
  logic            w_do_move;

  // Exactly one button pressed is a request; r_dir/w_left_req use 1 = left.
  assign w_left_req  = ~SC_RegJUGMOV_left_InLow &  SC_RegJUGMOV_right_InLow;
  assign w_right_req =  SC_RegJUGMOV_left_InLow & ~SC_RegJUGMOV_right_InLow;
  assign w_req       = w_left_req | w_right_req;

  // Result of one move in the requested direction, including the boundary flag.
  always_comb begin
    w_move_data = r_data;
    w_move_edge = 1'b0;
    if (w_left_req) begin
      w_move_edge = r_data[W-1];
      if (WRAP_MODE) begin
        w_move_data = {r_data[W-2:0], r_data[W-1]};
      end else if (!r_data[W-1]) begin
        w_move_data = {r_data[W-2:0], 1'b0};
      end
    end else if (w_right_req) begin
      w_move_edge = r_data[0];
      if (WRAP_MODE) begin
        w_move_data = {r_data[0], r_data[W-1:1]};
      end else if (!r_data[0]) begin
        w_move_data = {1'b0, r_data[W-1:1]};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_edge_nxt  = 1'b0;
    w_do_move   = 1'b0;

    if (!SC_RegJUGMOV_clear_InLow) begin
      w_data_nxt  = '0;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (!SC_RegJUGMOV_load_InLow) begin
      w_data_nxt  = DATA_INIT_POS;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (!w_req) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if ((r_state == ST_IDLE) || (w_left_req != r_dir)) begin
      // Fresh press (or direction change): move now and restart the hold-off delay.
      w_do_move   = 1'b1;
      w_dir_nxt   = w_left_req;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_DELAY;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_cnt == DelayLast) begin
            w_do_move   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_REPEAT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (r_cnt == PeriodLast) begin
            w_do_move = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // A blocked saturate move still counts as a move for timing purposes.
    if (w_do_move) begin
      w_data_nxt = w_move_data;
      w_edge_nxt = w_move_edge;
    end
  end

  always_ff @(posedge SC_RegJUGMOV_CLOCK_50 or negedge SC_RegJUGMOV_RESET_InLow) begin
    if (!SC_RegJUGMOV_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= DATA_INIT_POS;
      r_edge  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_edge  <= w_edge_nxt;
    end
  end

  assign SC_RegJUGMOV_data_OutBUS = r_data;
  assign SC_RegJUGMOV_edge_Out    = r_edge;

endmodule

// File: tb/tb_sc_reg_jug_mover.sv
// Bench for sc_reg_jug_mover: a wrapping and a saturating instance share stimulus and are
// compared every cycle against a time-since-press reference model.
module tb_sc_reg_jug_mover;

  localparam int D = 4;
  localparam int P = 2;

  logic       clk    = 1'b0;
  logic       rstN   = 1'b1;
  logic       clearN = 1'b1;
  logic       loadN  = 1'b1;
  logic       leftN  = 1'b1;
  logic       rightN = 1'b1;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       edgeA;
  logic       edgeB;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mData[2];
  logic       mEdge[2];
  int         mDir[2];
  int         mAge[2];
  logic [7:0] mInit[2] = '{8'b00011000, 8'b10000000};
  bit         mWrap[2] = '{1'b1, 1'b0};

  sc_reg_jug_mover #(
    .RegJUGMOV_DATAWIDTH(8),
    .DATA_INIT_POS      (8'b00011000),
    .WRAP_MODE          (1'b1),
    .REPEAT_DELAY       (D),
    .REPEAT_PERIOD      (P)
  ) dutWrap (
    .SC_RegJUGMOV_CLOCK_50    (clk),
    .SC_RegJUGMOV_RESET_InLow (rstN),
    .SC_RegJUGMOV_clear_InLow (clearN),
    .SC_RegJUGMOV_load_InLow  (loadN),
    .SC_RegJUGMOV_left_InLow  (leftN),
    .SC_RegJUGMOV_right_InLow (rightN),
    .SC_RegJUGMOV_data_OutBUS (dataA),
    .SC_RegJUGMOV_edge_Out    (edgeA)
  );

  sc_reg_jug_mover #(
    .RegJUGMOV_DATAWIDTH(8),
    .DATA_INIT_POS      (8'b10000000),
    .WRAP_MODE          (1'b0),
    .REPEAT_DELAY       (D),
    .REPEAT_PERIOD      (P)
  ) dutSat (
    .SC_RegJUGMOV_CLOCK_50    (clk),
    .SC_RegJUGMOV_RESET_InLow (rstN),
    .SC_RegJUGMOV_clear_InLow (clearN),
    .SC_RegJUGMOV_load_InLow  (loadN),
    .SC_RegJUGMOV_left_InLow  (leftN),
    .SC_RegJUGMOV_right_InLow (rightN),
    .SC_RegJUGMOV_data_OutBUS (dataB),
    .SC_RegJUGMOV_edge_Out    (edgeB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mData[k] = mInit[k];
      mEdge[k] = 1'b0;
      mDir[k]  = 0;
      mAge[k]  = 0;
    end
  endtask

  // Moves happen at press age 0, D, D+P, D+2P, ... counted in edges since the press.
  task automatic modelStep(input logic l, input logic r, input logic clr, input logic ld);
    int  req;
    int  v;
    bit  move;
    bit  carry;
    req = (!l && r) ? 1 : ((l && !r) ? 2 : 0);
    for (int k = 0; k < 2; k++) begin
      mEdge[k] = 1'b0;
      move = 1'b0;
      if (!clr) begin
        mData[k] = 8'd0;
        mDir[k]  = 0;
      end else if (!ld) begin
        mData[k] = mInit[k];
        mDir[k]  = 0;
      end else if (req == 0) begin
        mDir[k] = 0;
      end else if (req != mDir[k]) begin
        mDir[k] = req;
        mAge[k] = 0;
        move    = 1'b1;
      end else begin
        mAge[k]++;
        if (mAge[k] == D || (mAge[k] > D && (mAge[k] - D) % P == 0)) move = 1'b1;
      end
      if (move) begin
        v = int'(mData[k]);
        if (req == 1) begin
          carry = (v >= 128);
          if (mWrap[k]) v = (v * 2) % 256 + (carry ? 1 : 0);
          else if (!carry) v = v * 2;
        end else begin
          carry = (v % 2 == 1);
          if (mWrap[k]) v = v / 2 + (carry ? 128 : 0);
          else if (!carry) v = v / 2;
        end
        mData[k] = 8'(v);
        mEdge[k] = carry;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_dataWrap"}, 32'(dataA), 32'(mData[0]));
    checkOutput({tag, "_edgeWrap"}, 32'(edgeA), 32'(mEdge[0]));
    checkOutput({tag, "_dataSat"},  32'(dataB), 32'(mData[1]));
    checkOutput({tag, "_edgeSat"},  32'(edgeB), 32'(mEdge[1]));
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic clr, input logic ld, input string tag);
    leftN  = l;
    rightN = r;
    clearN = clr;
    loadN  = ld;
    @(posedge clk);
    modelStep(l, r, clr, ld);
    #1;
    checkAll(tag);
  endtask

  // Reset pulse placed between edges; outputs must change without any clock.
  task automatic asyncReset(input string tag);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "_rstDataWrap"}, 32'(dataA), 32'h18);
    checkOutput({tag, "_rstDataSat"},  32'(dataB), 32'h80);
    checkOutput({tag, "_rstEdgeWrap"}, 32'(edgeA), 32'h0);
    checkOutput({tag, "_rstEdgeSat"},  32'(edgeB), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [7:0] expLeft[10];
    logic       curL;
    logic       curR;
    expLeft = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h60, 8'h60, 8'hC0, 8'hC0, 8'h81, 8'h81};

    asyncReset("init");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "holdLeft");
      checkOutput("holdLeftTable", 32'(dataA), 32'(expLeft[i]));
      checkOutput("holdLeftEdge", 32'(edgeA), (i == 8) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "release");

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "loadPre");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, "holdRight");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "switchLeft");

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, (i == 5) ? 1'b0 : 1'b1, 1'b1, "clearHold");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "release2");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, (i == 3) ? 1'b0 : 1'b1, "loadHold");
    checkOutput("loadHoldMove", 32'(dataA), 32'h30);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "loadSat");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "satLeft");

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "bothLow");
    asyncReset("midCycle");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "afterReset");

    curL = 1'b1;
    curR = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        curL = 1'($urandom_range(0, 1));
        curR = 1'($urandom_range(0, 1));
      end
      applyStimulus(curL, curR,
                    ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                    "random");
      if ($urandom_range(0, 99) < 2) asyncReset("randomReset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
